add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter RR, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester n presents an operation.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1 each  operation n accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32 each  operands.
REQ-007 SHALL have ports req0_sub / req1_sub  input  1 each  1 = a-b, 0 = a+b.
REQ-008 SHALL have port res_valid  output  1  result register holds an unconsumed result.
REQ-009 SHALL have port res_ready  input  1  consumer takes the result.
REQ-010 SHALL have port res_id  output  1  requester that issued the held result.
REQ-011 SHALL have port res_out  output  32  registered sum/difference.
REQ-012 SHALL have port res_nzcv  output  4  registered NZCV flags, {N,Z,C,V}.
REQ-013 SHALL have port op_count  output  16  completed (consumed) results, wraps at 0xFFFF->0x0000.

Function
REQ-014 SHALL contain exactly one instance of the team 32-bit adder, with cin driven by the granted requester's sub bit, b pre-inversion left to the adder.
REQ-015 SHALL treat a request as accepted in a cycle iff reqN_valid && reqN_ready at the rising edge.
REQ-016 SHALL define slot_free = !res_valid || res_ready; no reqN_ready SHALL assert when slot_free is 0.
REQ-017 SHALL assert at most one of req0_ready/req1_ready per cycle.
REQ-018 With slot_free and only one requester valid, SHALL grant that requester.
REQ-019 With slot_free, both valid, RR=1: SHALL grant the requester indicated by pointer rr_ptr; RR=0: SHALL grant requester 0.
REQ-020 SHALL set rr_ptr to the non-granted requester after every acceptance; unchanged when nothing accepted.
REQ-021 SHALL compute reqN_ready combinationally from valids, slot_free and rr_ptr; ready MAY assert without valid only when that requester would win.
REQ-022 On acceptance SHALL load res_out, res_nzcv, res_id from the adder outputs and granted index, and set res_valid on the next edge (latency 1 cycle).
REQ-023 On res_valid && res_ready with no acceptance, SHALL clear res_valid and hold res_out/res_nzcv/res_id.
REQ-024 On simultaneous consume and accept, SHALL keep res_valid=1 and load the new result (sustained throughput 1 op/cycle).
REQ-025 While res_valid && !res_ready, res_out, res_nzcv, res_id SHALL stay stable.
REQ-026 SHALL increment op_count by 1 on every res_valid && res_ready edge, wrapping modulo 2^16.
REQ-027 SHALL ignore operand and sub inputs of a non-granted requester; the non-granted request SHALL remain pending, no drop.
REQ-028 Two-state controller: EMPTY (res_valid=0), FULL (res_valid=1); EMPTY->FULL on accept; FULL->EMPTY on consume without accept; FULL->FULL otherwise.

Reset
REQ-029 SHALL, while rst_n=0, force res_valid=0, res_id=0, res_out=0, res_nzcv=0, op_count=0, rr_ptr=0, state EMPTY, independent of clk.
REQ-030 SHALL discard any held result on reset mid-operation; no result of a pre-reset request appears afterwards.
REQ-031 SHALL assert req0_ready/req1_ready only from the first clk edge after rst_n deasserts onward (readies 0 during reset).

Verification
REQ-032 Single add: req0 a=5 b=3 sub=0, res_ready=1 -> next cycle res_valid=1, res_out=8, res_nzcv=0000, res_id=0, op_count=1 one edge later.
REQ-033 Subtract flags: req1 a=3 b=3 sub=1 -> res_out=0, res_nzcv Z=1 C=1 N=0 V=0, res_id=1; a=0x7FFFFFFF b=1 sub=0 -> res_out=0x80000000, N=1 V=1.
REQ-034 Contention RR=1: both valid continuously 4 cycles, res_ready=1 -> res_id sequence 0,1,0,1; RR=0 -> 0,0,0,0 with req1 stalled.
REQ-035 Backpressure: res_ready=0 for 3 cycles after one result -> res_out/res_id stable, both readies 0, no acceptance; res_ready=1 -> consume and accept same edge, op_count +1.
REQ-036 Wrap/reset: preload 0xFFFF consumes -> next consume op_count=0x0000; rst_n pulse low while FULL mid-cycle -> res_valid=0 immediately, op_count=0, rr_ptr=0.

Source files
------------

// File: rtl/add_arbiter.sv
// Two-requester add/subtract arbiter: one shared 32-bit adder feeding a
// single-entry result register, with round-robin or fixed-priority grant.

module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic [3:0]  nzcv
);
  logic [31:0] b_eff;
  logic [32:0] full;

  // cin doubles as the subtract select: a - b == a + ~b + 1
  always_comb begin
    b_eff = cin ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {32'd0, cin};
    sum   = full[31:0];
    nzcv  = {full[31], (full[31:0] == '0), full[32],
             (a[31] == b_eff[31]) && (full[31] != a[31])};
  end
endmodule

module add_arbiter #(
  parameter int RR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [31:0] res_out,
  output logic [3:0]  res_nzcv,
  output logic [15:0] op_count
);
  localparam bit RR_EN = (RR != 0);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state;
  logic        rr_ptr;
  logic        run;
  logic        slot_free;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        consume;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic [31:0] sum;
  logic [3:0]  nzcv;

  // run holds the readies low until the first edge after reset release
  always_comb begin
    slot_free = (state == EMPTY) || res_ready;
    grant0    = run && slot_free && req0_valid &&
                (!req1_valid || !RR_EN || !rr_ptr);
    grant1    = run && slot_free && req1_valid &&
                (!req0_valid || (RR_EN && rr_ptr));
    accept    = grant0 || grant1;
    consume   = (state == FULL) && res_ready;
    op_a      = grant1 ? req1_a   : req0_a;
    op_b      = grant1 ? req1_b   : req0_b;
    op_sub    = grant1 ? req1_sub : req0_sub;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res_valid  = (state == FULL);

  add32 u_add32 (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_sub),
    .sum  (sum),
    .nzcv (nzcv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rr_ptr   <= 1'b0;
      run      <= 1'b0;
      res_id   <= 1'b0;
      res_out  <= '0;
      res_nzcv <= '0;
      op_count <= '0;
    end else begin
      run <= 1'b1;
      if (consume) op_count <= op_count + 16'd1;
      if (accept) begin
        res_out  <= sum;
        res_nzcv <= nzcv;
        res_id   <= grant1;
        rr_ptr   <= grant0;
      end
      case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (consume && !accept) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_add_arbiter.sv
// Randomized self-checking bench for add_arbiter against a transaction-level
// model; a fixed-priority instance shares the stimulus for the contention case.

module tb_add_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic        res_ready = 1'b0;
  logic        req0_ready, req1_ready, res_valid, res_id;
  logic [31:0] res_out;
  logic [3:0]  res_nzcv;
  logic [15:0] op_count;
  logic        fp_req0_ready, fp_req1_ready, fp_res_valid, fp_res_id;
  logic [31:0] fp_res_out;
  logic [3:0]  fp_res_nzcv;
  logic [15:0] fp_op_count;

  int checks = 0;
  int errors = 0;

  // transaction-level model of the round-robin instance
  bit          m_valid, m_id, m_ptr, lg0, lg1;
  logic [31:0] m_out;
  logic [3:0]  m_nzcv;
  logic [15:0] m_cnt;

  add_arbiter #(.RR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_out(res_out),
    .res_nzcv(res_nzcv), .op_count(op_count)
  );

  add_arbiter #(.RR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .res_valid(fp_res_valid), .res_ready(res_ready), .res_id(fp_res_id), .res_out(fp_res_out),
    .res_nzcv(fp_res_nzcv), .op_count(fp_op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {N,Z,C,V,result} from plain signed/unsigned arithmetic
  function automatic logic [35:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint unsigned ua, ub, ur;
    longint sa, sb, sr, st;
    logic [31:0] r;
    logic c, v;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      ur = ua - ub; sr = sa - sb; c = (ua >= ub);
    end else begin
      ur = ua + ub; sr = sa + sb; c = (ur > 64'hFFFF_FFFF);
    end
    r  = ur[31:0];
    st = longint'($signed(r));
    v  = (sr != st);
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic void model_grant(output bit g0, output bit g1);
    bit free;
    free = !m_valid || res_ready;
    g0 = 1'b0; g1 = 1'b0;
    if (free) begin
      if (req0_valid && req1_valid) begin
        g1 = m_ptr; g0 = !m_ptr;
      end else begin
        g0 = req0_valid; g1 = req1_valid;
      end
    end
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_ptr = 0; m_out = '0; m_nzcv = '0; m_cnt = '0;
    lg0 = 0; lg1 = 0;
  endtask

  // one clock edge: model decides from the inputs present before the edge
  task automatic step();
    bit g0, g1, cons;
    logic [35:0] r;
    model_grant(g0, g1);
    cons = m_valid && res_ready;
    @(posedge clk);
    if (cons) m_cnt = m_cnt + 16'd1;
    if (g0 || g1) begin
      r = g1 ? ref_op(req1_a, req1_b, req1_sub) : ref_op(req0_a, req0_b, req0_sub);
      m_out = r[31:0]; m_nzcv = r[35:32]; m_id = g1; m_valid = 1; m_ptr = g0;
    end else if (cons) begin
      m_valid = 0;
    end
    lg0 = g0; lg1 = g1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 0; req1_valid = 0; res_ready = 0;
    rst_n = 0;
    #7;
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    req0_valid = 1; req1_valid = 1; res_ready = 1;
    #2;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_readies got %b%b want 00", req0_ready, req1_ready); end
    checks++; if (res_valid !== 1'b0 || res_id !== 1'b0) begin errors++; $display("FAIL reset_valid_id got %b %b want 0 0", res_valid, res_id); end
    checks++; if (res_out !== 32'd0 || res_nzcv !== 4'd0 || op_count !== 16'd0) begin errors++; $display("FAIL reset_regs got %h %b %h want zeros", res_out, res_nzcv, op_count); end
    checks++; if (fp_res_valid !== 1'b0 || fp_op_count !== 16'd0) begin errors++; $display("FAIL reset_fp got %b %h want 0 0", fp_res_valid, fp_op_count); end
    @(negedge clk);
    #2;
    rst_n = 1;
    model_reset();
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL release_readies got %b%b want 00", req0_ready, req1_ready); end
    @(posedge clk);
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL first_grant got %b%b want 10", req0_ready, req1_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL post_release_valid got %b want 0", res_valid); end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_single_add();
    do_reset();
    res_ready = 1; req0_valid = 1; req0_a = 5; req0_b = 3; req0_sub = 0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b want 1", req0_ready); end
    step();
    req0_valid = 0;
    checks++; if (res_valid !== 1'b1 || res_out !== 32'd8 || res_nzcv !== 4'b0000 || res_id !== 1'b0) begin
      errors++; $display("FAIL add_result got v=%b out=%h nzcv=%b id=%b want 1 8 0000 0", res_valid, res_out, res_nzcv, res_id); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL add_count_early got %h want 0", op_count); end
    step();
    checks++; if (op_count !== 16'd1 || res_valid !== 1'b0) begin errors++; $display("FAIL add_consume got cnt=%h v=%b want 1 0", op_count, res_valid); end
  endtask

  task automatic test_flags();
    do_reset();
    res_ready = 1; req1_valid = 1; req1_a = 3; req1_b = 3; req1_sub = 1;
    step();
    checks++; if (res_out !== 32'd0 || res_nzcv !== 4'b0110 || res_id !== 1'b1) begin
      errors++; $display("FAIL sub_zero got out=%h nzcv=%b id=%b want 0 0110 1", res_out, res_nzcv, res_id); end
    req1_a = 32'h7FFF_FFFF; req1_b = 1; req1_sub = 0;
    step();
    req1_valid = 0;
    checks++; if (res_out !== 32'h8000_0000 || res_nzcv !== 4'b1001) begin
      errors++; $display("FAIL add_ovf got out=%h nzcv=%b want 80000000 1001", res_out, res_nzcv); end
    checks++; if (res_out !== m_out || res_nzcv !== m_nzcv) begin errors++; $display("FAIL add_ovf_model got %h %b want %h %b", res_out, res_nzcv, m_out, m_nzcv); end
  endtask

  task automatic test_contention();
    bit [3:0] want_rr;
    want_rr = 4'b1010;
    do_reset();
    res_ready = 1; req0_valid = 1; req1_valid = 1;
    req0_a = 10; req0_b = 1; req0_sub = 0; req1_a = 20; req1_b = 2; req1_sub = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (fp_req1_ready !== 1'b0) begin errors++; $display("FAIL fp_req1_stall cycle %0d got %b want 0", i, fp_req1_ready); end
      step();
      checks++; if (res_id !== want_rr[i] || res_id !== m_id) begin errors++; $display("FAIL rr_sequence cycle %0d got %b want %b", i, res_id, want_rr[i]); end
      checks++; if (fp_res_id !== 1'b0 || fp_res_out !== 32'd11) begin errors++; $display("FAIL fp_sequence cycle %0d got id=%b out=%h want 0 b", i, fp_res_id, fp_res_out); end
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_reset();
    res_ready = 0; req0_valid = 1; req0_a = 100; req0_b = 1; req0_sub = 1;
    step();
    held = res_out;
    req1_valid = 1; req0_a = 7; req1_a = 9; req1_b = 4; req1_sub = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_readies cycle %0d got %b%b want 00", i, req0_ready, req1_ready); end
      step();
      checks++; if (res_out !== 32'd99 || res_out !== held || res_id !== 1'b0 || res_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold cycle %0d got out=%h id=%b v=%b want 63 0 1", i, res_out, res_id, res_valid); end
    end
    res_ready = 1;
    #1;
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL bp_release_ready got %b%b want 01", req0_ready, req1_ready); end
    step();
    req0_valid = 0; req1_valid = 0;
    checks++; if (res_valid !== 1'b1 || res_id !== 1'b1 || res_out !== 32'd13 || op_count !== 16'd1) begin
      errors++; $display("FAIL bp_swap got v=%b id=%b out=%h cnt=%h want 1 1 d 1", res_valid, res_id, res_out, op_count); end
  endtask

  task automatic test_wrap_reset();
    int guard;
    do_reset();
    res_ready = 1; req0_valid = 1;
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom);
      step();
      guard++;
    end
    checks++; if (op_count !== 16'hFFFF || m_cnt !== 16'hFFFF) begin errors++; $display("FAIL preload_count got %h want ffff", op_count); end
    checks++; if (res_out !== m_out || res_nzcv !== m_nzcv) begin errors++; $display("FAIL stream_result got %h %b want %h %b", res_out, res_nzcv, m_out, m_nzcv); end
    step();
    checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL wrap_count got %h want 0000", op_count); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL full_before_reset got %b want 1", res_valid); end
    #3;
    rst_n = 0;
    #1;
    checks++; if (res_valid !== 1'b0 || op_count !== 16'd0 || res_out !== 32'd0) begin
      errors++; $display("FAIL async_reset got v=%b cnt=%h out=%h want 0 0 0", res_valid, op_count, res_out); end
    req0_valid = 0;
    #3;
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stale_result got %b want 0", res_valid); end
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL ptr_reset got %b%b want 10", req0_ready, req1_ready); end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_random();
    bit g0, g1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (lg0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom);
        if ($urandom_range(0, 7) == 0) req0_b = req0_a;
      end
      if (lg1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom);
      end
      res_ready = ($urandom_range(0, 2) != 0);
      #1;
      model_grant(g0, g1);
      checks++; if (req0_ready !== g0 || req1_ready !== g1) begin errors++; $display("FAIL rand_ready cycle %0d got %b%b want %b%b", i, req0_ready, req1_ready, g0, g1); end
      step();
      checks++; if (res_valid !== m_valid || op_count !== m_cnt) begin errors++; $display("FAIL rand_state cycle %0d got v=%b cnt=%h want %b %h", i, res_valid, op_count, m_valid, m_cnt); end
      if (m_valid) begin
        checks++; if (res_out !== m_out || res_nzcv !== m_nzcv || res_id !== m_id) begin
          errors++; $display("FAIL rand_result cycle %0d got %h %b %b want %h %b %b", i, res_out, res_nzcv, res_id, m_out, m_nzcv, m_id); end
      end
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_add();
    test_flags();
    test_contention();
    test_backpressure();
    test_random();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
